// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-fetch front end: default geometry,
// fetch FSM states and the prefetch FIFO entry layout.
package imem_pkg;

    localparam int IMEM_N        = 32;
    localparam int IMEM_R        = 7;
    localparam int IMEM_END_ADDR = 'h40;
    localparam int FIFO_DEPTH    = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [IMEM_R-1:0] pc;
        logic [IMEM_N-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bus between the fetch controller, the combinational imem and decode.
interface imem_fetch_ctrl_if
    import imem_pkg::*;
#(
    parameter int N = IMEM_N,
    parameter int R = IMEM_R
);
    logic [R-1:0] imem_addr;
    logic [N-1:0] imem_data;
    logic         instr_valid;
    logic         instr_ready;
    logic [N-1:0] instr_data;
    logic [R-1:0] instr_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output instr_valid,
        input  instr_ready,
        output instr_data,
        output instr_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr_valid,
        output instr_ready,
        input  instr_data,
        input  instr_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO; flush has priority over push and pop, and the head
// reads as zero while empty.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 39,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [W-1:0]  head
);
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic [AW:0]    count_next;
    logic [W-1:0]   mem_reg [DEPTH];
    logic [DEPTH-1:0] wr_sel;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop) && !flush;
    assign count   = count_reg;
    assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = do_push && (wr_ptr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) mem_reg[i] <= din;
            end
        end
    end

    always_comb begin
        count_next = count_reg;
        if (do_push && !do_pop)      count_next = count_reg + 1'b1;
        else if (!do_push && do_pop) count_next = count_reg - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, sequences the combinational imem
// into a prefetch FIFO and handles redirects and end-of-program drain.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int           N        = IMEM_N,
    parameter int           R        = IMEM_R,
    parameter int           DEPTH    = FIFO_DEPTH,
    parameter logic [R-1:0] END_ADDR = R'(IMEM_END_ADDR)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 redir_valid,
    input  logic [R-1:0]         redir_addr,
    output logic                 done,
    imem_fetch_ctrl_if.master    bus
);
    localparam int AW = $clog2(DEPTH);

    fetch_state_t     state_reg, state_next;
    logic [R-1:0]     pc_reg, pc_next;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [R+N-1:0]   fifo_head;

    assign bus.imem_addr   = pc_reg;
    assign bus.instr_valid = !fifo_empty;
    assign {bus.instr_pc, bus.instr_data} = fifo_head;
    assign pop  = bus.instr_valid && bus.instr_ready;
    assign done = (state_reg == HALT);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (R + N)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (redir_valid),
        .din   ({pc_reg, bus.imem_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push       = 1'b0;
        if (redir_valid) begin
            // Redirect wins over any push or pop this cycle.
            pc_next    = redir_addr;
            state_next = en ? FETCH : IDLE;
        end else begin
            case (state_reg)
                IDLE: if (en) state_next = FETCH;
                FETCH: begin
                    if (en && (!fifo_full || pop)) begin
                        push    = 1'b1;
                        pc_next = pc_reg + 1'b1;
                        if (pc_reg == END_ADDR) state_next = DRAIN;
                    end
                end
                DRAIN: if (fifo_count == '0) state_next = HALT;
                HALT:  state_next = HALT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based model of the fetch pipeline.
module tb_imem_fetch_ctrl;
    import imem_pkg::*;

    localparam int N     = 32;
    localparam int R     = 7;
    localparam int DEPTH = 4;
    localparam int ENDA  = 'h40;
    localparam int M_IDLE = 0, M_FETCH = 1, M_DRAIN = 2, M_HALT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         redir_valid = 1'b0;
    logic [R-1:0] redir_addr = '0;
    logic         instr_ready = 1'b0;
    logic         done;

    logic [N-1:0] mem [128];

    imem_fetch_ctrl_if #(.N(N), .R(R)) bus ();

    imem_fetch_ctrl #(
        .N(N), .R(R), .DEPTH(DEPTH), .END_ADDR(7'h40)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .redir_valid (redir_valid),
        .redir_addr  (redir_addr),
        .done        (done),
        .bus         (bus)
    );

    assign bus.imem_data   = mem[bus.imem_addr];
    assign bus.instr_ready = instr_ready;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int last_pc = -1;
    bit verbose = 1'b1;

    // Model: a queue of fetched entries, the next fetch address, and the phase.
    fetch_entry_t mq[$];
    int mpc = 0;
    int mmode = M_IDLE;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        mpc   = 0;
        mmode = M_IDLE;
    endfunction

    function automatic void model_step();
        int sz;
        bit pop_m;
        bit push_m;
        fetch_entry_t e;
        sz = mq.size();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (redir_valid) begin
            mq.delete();
            mpc   = int'(redir_addr);
            mmode = en ? M_FETCH : M_IDLE;
            return;
        end
        pop_m  = (sz > 0) && instr_ready;
        push_m = (mmode == M_FETCH) && en && ((sz < DEPTH) || pop_m);
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
            e.pc    = 7'(mpc);
            e.instr = mem[mpc];
            mq.push_back(e);
            if (mpc == ENDA) mmode = M_DRAIN;
            mpc = (mpc + 1) % 128;
        end else if (mmode == M_IDLE && en) begin
            mmode = M_FETCH;
        end else if (mmode == M_DRAIN && sz == 0) begin
            mmode = M_HALT;
        end
    endfunction

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("instr_valid", 64'(bus.instr_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("instr_pc", 64'(bus.instr_pc), 64'(mq[0].pc));
                chk("instr_data", 64'(bus.instr_data), 64'(mq[0].instr));
            end
            chk("imem_addr", 64'(bus.imem_addr), 64'(mpc));
            chk("done", 64'(done), 64'(mmode == M_HALT));
            chk("fifo_count", 64'(dut.fifo_count), 64'(mq.size()));
        end
    end

    task automatic cycle();
        if (rst_n && bus.instr_valid && instr_ready && !redir_valid) begin
            last_pc = int'(bus.instr_pc);
            if (verbose) $display("accept pc=%02h data=%08h", bus.instr_pc, bus.instr_data);
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        en = 1'b0;
        redir_valid = 1'b0;
        instr_ready = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic [R-1:0] addr);
        if (verbose) $display("redirect to %02h", addr);
        redir_valid = 1'b1;
        redir_addr  = addr;
        cycle();
        redir_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 128; k++) mem[k] = 32'h1000_0000 + k;

        // 1: first instruction two cycles after en rises, then one per cycle
        do_reset();
        instr_ready = 1'b1;
        en = 1'b1;
        cycle();
        chk("t1_not_yet_valid", 64'(bus.instr_valid), 64'd0);
        cycle();
        chk("t1_first_valid", 64'(bus.instr_valid), 64'd1);
        chk("t1_first_pc", 64'(bus.instr_pc), 64'h0);
        chk("t1_first_data", 64'(bus.instr_data), 64'h1000_0000);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("t1_stream_pc", 64'(bus.instr_pc), 64'(k));
        end

        // 2: back-pressure fills exactly DEPTH entries
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        repeat (10) cycle();
        chk("t2_pc_stops", 64'(bus.imem_addr), 64'h4);
        chk("t2_head_pc", 64'(bus.instr_pc), 64'h0);
        chk("t2_head_data", 64'(bus.instr_data), 64'h1000_0000);
        instr_ready = 1'b1;
        cycle();
        chk("t2_resume_pc", 64'(bus.instr_pc), 64'h1);

        // 3: run to END_ADDR, drain and halt
        for (int i = 0; i < 300 && !done; i++) cycle();
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_last_pc", 64'(last_pc), 64'h40);
        chk("t3_addr_hold", 64'(bus.imem_addr), 64'h41);
        repeat (5) cycle();
        chk("t3_addr_still", 64'(bus.imem_addr), 64'h41);
        chk("t3_no_more", 64'(bus.instr_valid), 64'd0);

        // 4: redirect mid-stream with three entries queued
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        for (int i = 0; i < 20 && mq.size() < 3; i++) cycle();
        chk("t4_count3", 64'(dut.fifo_count), 64'd3);
        instr_ready = 1'b1;
        redirect(7'h10);
        chk("t4_flushed", 64'(bus.instr_valid), 64'd0);
        cycle();
        chk("t4_target_pc", 64'(bus.instr_pc), 64'h10);
        chk("t4_target_data", 64'(bus.instr_data), 64'h1000_0010);

        // 5: redirect out of HALT with wrap-around
        for (int i = 0; i < 300 && !done; i++) cycle();
        chk("t5_halted", 64'(done), 64'd1);
        redirect(7'h7E);
        chk("t5_done_clear", 64'(done), 64'd0);
        chk("t5_flushed", 64'(bus.instr_valid), 64'd0);
        cycle();
        chk("t5_pc_7e", 64'(bus.instr_pc), 64'h7E);
        cycle();
        chk("t5_pc_7f", 64'(bus.instr_pc), 64'h7F);
        cycle();
        chk("t5_pc_00", 64'(bus.instr_pc), 64'h00);
        for (int i = 0; i < 300 && !done; i++) cycle();
        chk("t5_done_again", 64'(done), 64'd1);
        chk("t5_last_pc", 64'(last_pc), 64'h40);

        // 6: asynchronous reset between edges mid-fill
        do_reset();
        en = 1'b1;
        instr_ready = 1'b0;
        repeat (4) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid_low", 64'(bus.instr_valid), 64'd0);
        chk("t6_addr_zero", 64'(bus.imem_addr), 64'd0);
        chk("t6_done_low", 64'(done), 64'd0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("t6_restart_wait", 64'(bus.instr_valid), 64'd0);
        cycle();
        chk("t6_restart_valid", 64'(bus.instr_valid), 64'd1);
        chk("t6_restart_pc", 64'(bus.instr_pc), 64'h0);

        // Randomized traffic against the model
        verbose = 1'b0;
        for (int k = 0; k < 128; k++) mem[k] = $urandom;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            instr_ready = ($urandom_range(0, 9) < 7);
            redir_valid = ($urandom_range(0, 49) == 0);
            redir_addr  = 7'($urandom_range(0, 127));
            cycle();
        end
        redir_valid = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
